// File: rtl/pt_arbiter.sv
// pt_arbiter: round-robin burst arbiter sharing one registered byte stage
// toward the passthrough data_in; out_src tags each byte with its requester.
`default_nettype none

module pt_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(N_REQ)-1:0]   out_src,
  output logic                       busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic [IDX_W-1:0]    out_src_q, out_src_d;
  logic                busy_q, busy_d;

  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;
  logic [IDX_W-1:0]    scan;
  logic                can_take;
  logic                beat;
  logic                release_grant;
  logic [DATA_W-1:0]   owner_data;

  // Explicit wrap keeps the index legal when N_REQ is not a power of two.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan       = ptr_q;
    for (int k = 0; k < N_REQ; k++) begin
      if (!pick_found && req_valid[scan]) begin
        pick_found = 1'b1;
        pick_idx   = scan;
      end
      scan = next_idx(scan);
    end
  end

  assign can_take      = !out_valid_q || out_ready;
  assign owner_data    = req_data[owner_q*DATA_W +: DATA_W];
  assign beat          = (state_q == GRANT) && req_valid[owner_q] && can_take;
  assign release_grant = beat && (req_last[owner_q] || beat_cnt_q == LAST_BEAT);
  assign req_ready     = ((state_q == GRANT) && can_take) ? (N_REQ'(1) << owner_q) : '0;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    beat_cnt_d  = beat_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_src_d   = out_src_q;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
        if (release_grant) begin
          ptr_d   = next_idx(owner_q);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A drain and a new beat in the same cycle leave the stage full.
    if (beat) begin
      out_data_d  = owner_data;
      out_src_d   = owner_q;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    busy_d = (state_d == GRANT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      ptr_q       <= '0;
      beat_cnt_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
      busy_q      <= busy_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_pt_arbiter.sv
// tb_pt_arbiter: scoreboard bench for pt_arbiter; requester queues feed the
// DUT and each output byte is popped against the expected {src,data} queue.
`default_nettype none

module tb_pt_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NR-1:0]  req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  req_last;
  logic [NR-1:0]  req_ready;
  logic [DW-1:0]  out_data;
  logic           out_valid;
  logic           out_ready;
  logic [1:0]     out_src;
  logic           busy;

  pt_arbiter #(.N_REQ(NR), .DATA_W(DW), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  logic [8:0]  rq [NR][$];
  logic [11:0] exp_q [$];
  logic [NR-1:0] en;
  logic [NR-1:0] rr_s;
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int gap_chk = 0;
  bit gap_first = 1'b1;
  int last_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (en[i] && rq[i].size() > 0) begin
        req_valid[i]        = 1'b1;
        req_data[i*DW +: DW] = rq[i][0][7:0];
        req_last[i]         = rq[i][0][8];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[i*DW +: DW] = 8'h00;
        req_last[i]         = 1'b0;
      end
    end
  endtask

  // One clock: sample handshakes mid-cycle, then retire accepted beats.
  task automatic step();
    logic [NR-1:0] fire;
    logic [11:0]   e;
    drive();
    @(negedge clk);
    rr_s = req_ready;
    fire = req_valid & req_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", {24'h0, out_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("out_src", {30'h0, out_src}, {28'h0, e[11:8]});
        check("out_data", {24'h0, out_data}, {24'h0, e[7:0]});
        if (gap_chk != 0 && !gap_first) check("xfer_gap", cyc - last_cyc, gap_chk);
        gap_first = 1'b0;
        last_cyc  = cyc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NR; i++) if (fire[i]) void'(rq[i].pop_front());
  endtask

  task automatic load(input int r, input logic [7:0] d, input bit last, input bit exp);
    rq[r].push_back({last, d});
    if (exp) exp_q.push_back({4'(r), d});
  endtask

  task automatic expect_out(input int r, input logic [7:0] d);
    exp_q.push_back({4'(r), d});
  endtask

  task automatic check_reset_outputs();
    check("rst_out_valid", {31'h0, out_valid}, 0);
    check("rst_out_data", {24'h0, out_data}, 0);
    check("rst_out_src", {30'h0, out_src}, 0);
    check("rst_req_ready", {28'h0, req_ready}, 0);
    check("rst_busy", {31'h0, busy}, 0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    for (int i = 0; i < NR; i++) rq[i].delete();
    exp_q.delete();
    drive();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < max_cyc) begin
      step();
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b1;
    en = '1;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    rst_n = 1'b1;

    // Reset mid-burst, then pointer restarts at 0 so requester 1 beats 3.
    gap_chk = 0;
    load(1, 8'h41, 1'b0, 1'b1);
    load(1, 8'h42, 1'b0, 1'b0);
    load(1, 8'h43, 1'b0, 1'b0);
    load(1, 8'h44, 1'b0, 1'b0);
    step(); step(); step();
    check("mid_busy", {31'h0, busy}, 1);
    check("mid_out_data", {24'h0, out_data}, 32'h42);
    do_reset();
    load(1, 8'h71, 1'b1, 1'b1);
    load(3, 8'h73, 1'b1, 1'b1);
    drain(20);

    // Single burst of three from requester 1.
    gap_chk = 1; gap_first = 1'b1;
    load(1, 8'h11, 1'b0, 1'b1);
    load(1, 8'h22, 1'b0, 1'b1);
    load(1, 8'h33, 1'b1, 1'b1);
    step();
    check("sb_busy_grant", {31'h0, busy}, 1);
    step(); step(); step();
    check("sb_busy_fall", {31'h0, busy}, 0);
    check("sb_last_data", {24'h0, out_data}, 32'h33);
    step();
    check("sb_idle_ready", {28'h0, rr_s}, 0);
    check("sb_idle_busy", {31'h0, busy}, 0);
    drain(10);

    // Fairness: everyone valid, one-beat bursts, every other cycle.
    do_reset();
    gap_chk = 2; gap_first = 1'b1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NR; i++) load(i, 8'(8'h30 + 8*k + i), 1'b1, 1'b1);
    drain(40);

    // Burst cap: requester 2 cut after four beats, requester 3 next.
    gap_chk = 0;
    for (int k = 0; k < 6; k++) load(2, 8'(8'hA0 + k), (k == 5), 1'b0);
    load(3, 8'hB3, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) expect_out(2, 8'(8'hA0 + k));
    expect_out(3, 8'hB3);
    expect_out(2, 8'hA4);
    expect_out(2, 8'hA5);
    drain(40);

    // Backpressure: hold 0x5C for three cycles.
    load(0, 8'h5C, 1'b0, 1'b1);
    load(0, 8'h5D, 1'b0, 1'b1);
    load(0, 8'h5E, 1'b1, 1'b1);
    step(); step();
    check("bp_first", {24'h0, out_data}, 32'h5C);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_hold_data", {24'h0, out_data}, 32'h5C);
      check("bp_hold_valid", {31'h0, out_valid}, 1);
      check("bp_ready_low", {28'h0, rr_s}, 0);
    end
    out_ready = 1'b1;
    step();
    check("bp_resume", {28'h0, rr_s}, 32'h1);
    drain(20);

    // Owner stall: requester 0 goes quiet; requester 2 must wait.
    do_reset();
    load(0, 8'h60, 1'b0, 1'b1);
    load(0, 8'h61, 1'b1, 1'b1);
    load(2, 8'h62, 1'b1, 1'b1);
    step(); step();
    en[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("st_busy", {31'h0, busy}, 1);
      check("st_rdy2", {31'h0, rr_s[2]}, 0);
    end
    en[0] = 1'b1;
    step();
    check("st_last_fire", {28'h0, rr_s}, 32'h1);
    check("st_release", {31'h0, busy}, 0);
    step();
    check("st_idle_ready", {28'h0, rr_s}, 0);
    check("st_regrant", {31'h0, busy}, 1);
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pt_arbiter.md
# pt_arbiter

Round-robin arbiter that shares the 8-bit passthrough datapath between several requesters. Each requester presents bytes on a valid/ready port. The arbiter grants one requester at a time for a burst, then registers the accepted bytes onto a single output stage that feeds the passthrough `data_in`. It sits directly upstream of the passthrough block and also reports which source owns each output byte.

## Interface

Parameters:

- `N_REQ`, 4: number of requesters, from 2 to 8.
- `DATA_W`, 8: byte width, matching the passthrough datapath.
- `MAX_BURST`, 4: maximum beats per grant, from 1 to 16.

Ports:

- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in N_REQ: per-requester data valid.
- `req_data` in N_REQ*DATA_W: requester i occupies bits [i*DATA_W +: DATA_W].
- `req_last` in N_REQ: final beat of the requester's burst; sampled on transfer.
- `req_ready` out N_REQ: one-hot or zero; high only for the current owner when the output stage can accept.
- `out_data` out DATA_W: registered byte to the passthrough `data_in`.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: downstream accepts `out_data`.
- `out_src` out clog2(N_REQ): index of the requester that produced `out_data`.
- `busy` out 1: high while in GRANT.

## Operation

- **State machine:** states are IDLE and GRANT. Registers are `owner`, `ptr` (round-robin start), and `beat_cnt` (width clog2(MAX_BURST)+1).
- **IDLE:**
  - If any `req_valid` is high, select the first asserted index scanning `ptr`, `ptr`+1, … modulo N_REQ.
  - Register it as `owner`, clear `beat_cnt`, and go to GRANT.
  - If no `req_valid` is high, stay in IDLE.
  - `req_ready` is all zero in IDLE.
- **Output-stage space:** `can_take` = !`out_valid` || `out_ready`.
- **GRANT:**
  - `req_ready[owner]` = `can_take`; all other bits are 0.
  - A beat occurs when `req_valid[owner]` && `req_ready[owner]`.
  - On a beat: `out_data` ← `req_data[owner]`, `out_src` ← `owner`, `out_valid` ← 1, and `beat_cnt` increments.
- **Release:**
  - A beat with `req_last[owner]`=1, or a beat with `beat_cnt` == MAX_BURST-1, ends the grant.
  - On release: `ptr` ← (`owner`+1) mod N_REQ, then return to IDLE.
- **Owner drops valid mid-burst:** the grant is held indefinitely. Other requesters are not served until the owner completes or reset occurs.
- **Output register:**
  - `out_valid` clears when `out_ready`=1 and there is no beat that cycle.
  - A simultaneous drain and new beat keeps `out_valid`=1 with the new data.
  - While `out_valid`=1 and `out_ready`=0, `out_data` and `out_src` hold stable.
- **Counter width:** `ptr` wraps modulo N_REQ; when N_REQ is not a power of two, wrap explicitly from N_REQ-1 to 0.
- **Reset (async assert, sync release), including mid-burst:**
  - State = IDLE; `owner`, `ptr`, `beat_cnt` = 0.
  - `out_valid` = 0, `out_data` = 0, `out_src` = 0.
  - `req_ready` = 0, `busy` = 0.
  - The in-flight burst is discarded and is not resumed.

## Timing

- **Arbitration latency:** `req_valid` high in IDLE at cycle t gives GRANT in t+1. `req_ready` goes high in t+1, combinational from state and `can_take`.
- **Data latency:** a beat accepted in cycle c appears on `out_data`/`out_valid` in c+1.
- **Throughput:** 1 beat per cycle within a grant when `out_ready` is held at 1.
- **Inter-burst gap:** exactly one IDLE cycle between consecutive grants, including re-grant to the same requester.
- **Combinational paths:** `req_ready` depends combinationally on `out_ready`. No combinational path exists from `req_valid` or `req_data` to any output.
- **`busy`:** registered; equals (state == GRANT).

## Test plan

1. **Reset mid-burst:** requester 1 is in GRANT after 2 beats; pull `rst_n` low between edges. Required: all outputs are 0 immediately; after release, requesters 1 and 3 both valid → requester 0 is scanned first and requester 1 is granted.
2. **Single burst:** requester 1 sends 0x11, 0x22, 0x33 with `req_last` on 0x33, `out_ready`=1. Required:
   - `out_data` = 0x11/0x22/0x33 on consecutive cycles, with `out_src`=1.
   - `busy` falls after the third beat.
   - One IDLE cycle follows.
3. **Fairness:** all four requesters continuously valid, `req_last`=1 every beat. Required: grant order 0,1,2,3,0,1…, one beat each, separated by a single IDLE cycle.
4. **Burst cap:** MAX_BURST=4; requester 2 offers 6 beats 0xA0–0xA5 with no `req_last`; requester 3 is valid. Required:
   - 0xA0–0xA3 go out, then release.
   - Requester 3 is granted next.
   - Requester 2 resumes with 0xA4 on its following grant.
5. **Backpressure:** `out_valid`=1 with `out_data`=0x5C; hold `out_ready`=0 for 3 cycles. Required:
   - `out_data` is stable at 0x5C.
   - `req_ready`=0 throughout, with no beat lost or duplicated.
   - Transfer resumes the cycle `out_ready` returns high.
6. **Owner stall:** requester 0 drops `req_valid` after 1 beat while requester 2 is valid. Required:
   - `busy` stays 1.
   - `req_ready[2]`=0 until requester 0 sends a beat with `req_last`.
   - Requester 2 is then granted after one IDLE cycle.
